// File: rtl/cla_multiword_seq_adder.sv
// Purpose: W-bit adder (W = 16*WORDS) that pushes one 16-bit chunk per cycle through a single CLA.
// Latency: start accepted at edge T, done pulses in the cycle after edge T+WORDS.
// Backpressure: start is ignored while busy; a held start is accepted each time IDLE is reached.

// 16-bit adder: per-nibble group propagate/generate feeding a lookahead carry unit.
module cla_16bits_LCU (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout,
   output logic        P,
   output logic        G
);
   logic [15:0] p;
   logic [15:0] g;
   logic [3:0]  gp;
   logic [3:0]  gg;
   logic [4:0]  c;

   assign p = a ^ b;
   assign g = a & b;

   // Group propagate/generate for each nibble.
   always_comb begin
      gp = '0;
      gg = '0;
      for (int j = 0; j < 4; j++) begin
         gp[j] = &p[4*j +: 4];
         gg[j] = g[4*j+3]
               | (p[4*j+3] & g[4*j+2])
               | (p[4*j+3] & p[4*j+2] & g[4*j+1])
               | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      end
   end

   // Lookahead carry unit: nibble carry-ins straight from group P/G and cin.
   always_comb begin
      c    = '0;
      c[0] = cin;
      c[1] = gg[0] | (gp[0] & cin);
      c[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
      c[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
           | (gp[2] & gp[1] & gp[0] & cin);
      c[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
           | (gp[3] & gp[2] & gp[1] & gg[0]) | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
   end

   // Bit sums inside each nibble, seeded by the lookahead nibble carry.
   always_comb begin
      logic bc;
      sum = '0;
      bc  = 1'b0;
      for (int j = 0; j < 4; j++) begin
         bc = c[j];
         for (int k = 0; k < 4; k++) begin
            sum[4*j+k] = p[4*j+k] ^ bc;
            bc         = g[4*j+k] | (p[4*j+k] & bc);
         end
      end
   end

   assign cout = c[4];
   assign P    = &gp;
   assign G    = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
               | (gp[3] & gp[2] & gp[1] & gg[0]);
endmodule

module cla_multiword_seq_adder #(
   parameter int WORDS = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [16*WORDS-1:0] a,
   input  logic [16*WORDS-1:0] b,
   input  logic                cin,
   output logic                busy,
   output logic                done,
   output logic [16*WORDS-1:0] sum,
   output logic                cout,
   output logic                overflow
);
   localparam int W  = 16 * WORDS;
   localparam int IW = $clog2(WORDS);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            carry_q, carry_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [W-1:0]    sum_q, sum_d;
   logic            cout_q, cout_d;
   logic            ovf_q, ovf_d;

   logic [15:0]     cla_a;
   logic [15:0]     cla_b;
   logic [15:0]     cla_sum;
   logic            cla_cout;

   // Pick the operand chunk addressed by idx for the shared CLA.
   always_comb begin
      cla_a = '0;
      cla_b = '0;
      for (int k = 0; k < WORDS; k++) begin
         if (idx_q == IW'(k)) begin
            cla_a = a_q[16*k +: 16];
            cla_b = b_q[16*k +: 16];
         end
      end
   end

   cla_16bits_LCU u_cla (
      .a    (cla_a),
      .b    (cla_b),
      .cin  (carry_q),
      .sum  (cla_sum),
      .cout (cla_cout),
      .P    (),
      .G    ()
   );

   // Next-state and datapath updates: latch on accept, one chunk per RUN cycle.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               idx_d   = '0;
               sum_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            for (int k = 0; k < WORDS; k++) begin
               if (idx_q == IW'(k)) begin
                  sum_d[16*k +: 16] = cla_sum;
               end
            end
            carry_d = cla_cout;
            idx_d   = idx_q + 1'b1;
            if (idx_q == IW'(WORDS-1)) begin
               cout_d  = cla_cout;
               ovf_d   = (a_q[W-1] == b_q[W-1]) && (cla_sum[15] != a_q[W-1]);
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register; reset aborts any in-flight operation at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DONE);
   assign sum      = sum_q;
   assign cout     = cout_q;
   assign overflow = ovf_q;
endmodule
